system_x: RTL and testbench



---
 rtl/system_x.sv | 75 +++++++
 tb/tb_system_x.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/system_x.sv
// Registered 2-bit magnitude comparator: X={A,B} against W={C,D}, one-cycle latency.
// Optional Y toggle counter on TOGGLES, enabled by defining SYSTEMX_TOGGLE_CNT_EN.
module system_x (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic Y,
  output logic EQ,
  output logic LT,
  output logic VALID
`ifdef SYSTEMX_TOGGLE_CNT_EN
  ,
  output logic [7:0] TOGGLES
`endif
);

  logic [1:0] x_op;
  logic [1:0] w_op;
  logic       gt_d, eq_d, lt_d;
  logic       y_q, eq_q, lt_q, valid_q;

  assign x_op = {A, B};
  assign w_op = {C, D};

  always_comb begin
    gt_d = 1'b0;
    eq_d = 1'b0;
    lt_d = 1'b0;
    if (x_op > w_op)       gt_d = 1'b1;
    else if (x_op == w_op) eq_d = 1'b1;
    else                   lt_d = 1'b1;
  end

  // Flags are one-hot except while in reset, where all three read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      valid_q <= 1'b1;
    end
  end

  assign Y     = y_q;
  assign EQ    = eq_q;
  assign LT    = lt_q;
  assign VALID = valid_q;

`ifdef SYSTEMX_TOGGLE_CNT_EN
  logic [7:0] tog_q;
  logic [7:0] tog_d;

  // Counts edges where Y changes value; holds at 255 rather than wrapping.
  always_comb begin
    tog_d = tog_q;
    if ((gt_d != y_q) && (tog_q != 8'hFF)) tog_d = tog_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) tog_q <= 8'd0;
    else     tog_q <= tog_d;
  end

  assign TOGGLES = tog_q;
`endif

endmodule

// File: tb/tb_system_x.sv
// Bench for system_x: per-cycle reference model compare plus hand-tabled directed checks.
// Exercises the toggle counter when SYSTEMX_TOGGLE_CNT_EN is defined.
module tb_system_x;

  logic clk;
  logic rst;
  logic a, b, c, d;
  logic y, eq, lt, valid;
`ifdef SYSTEMX_TOGGLE_CNT_EN
  logic [7:0] toggles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 1'b1;

  logic [2:0] exp_q[$];

  system_x dut (
    .clk   (clk),
    .rst   (rst),
    .A     (a),
    .B     (b),
    .C     (c),
    .D     (d),
    .Y     (y),
    .EQ    (eq),
    .LT    (lt),
    .VALID (valid)
`ifdef SYSTEMX_TOGGLE_CNT_EN
    ,
    .TOGGLES (toggles)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Outputs are simply "what the comparison of the last sampled operands was".
  logic       m_y, m_eq, m_lt, m_valid;
  int         m_tog;

  always @(posedge clk) begin
    int xv, wv;
    xv = {a, b};
    wv = {c, d};
    if (rst) begin
      m_y <= 0; m_eq <= 0; m_lt <= 0; m_valid <= 0; m_tog <= 0;
    end else begin
      m_y     <= (xv > wv);
      m_eq    <= (xv == wv);
      m_lt    <= (xv < wv);
      m_valid <= 1'b1;
      if (((xv > wv) ? 1'b1 : 1'b0) != m_y && m_tog < 255) m_tog <= m_tog + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_cmp && $time > 0) begin
      check("model_y", {31'd0, y}, {31'd0, m_y});
      check("model_eq", {31'd0, eq}, {31'd0, m_eq});
      check("model_lt", {31'd0, lt}, {31'd0, m_lt});
      check("model_valid", {31'd0, valid}, {31'd0, m_valid});
      if (m_valid) check("one_hot", $countones({y, eq, lt}), 32'd1);
`ifdef SYSTEMX_TOGGLE_CNT_EN
      check("model_toggles", {24'd0, toggles}, m_tog);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    {a, b, c, d} = v;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] y_tbl;
  logic [15:0] eq_tbl;
  logic [15:0] lt_tbl;
  logic [2:0]  got;

  initial begin
    y_tbl  = 16'h7310;
    eq_tbl = 16'h8421;
    lt_tbl = 16'h08CE;

    // Reset held two cycles with X=3, W=0 on the inputs.
    rst = 1'b1;
    {a, b, c, d} = 4'b1100;
    after_edge();
    after_edge();
    check("reset_flags", {29'd0, y, eq, lt}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
`ifdef SYSTEMX_TOGGLE_CNT_EN
    check("reset_toggles", {24'd0, toggles}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    after_edge();
    check("release_flags", {29'd0, y, eq, lt}, 32'b100);
    check("release_valid", {31'd0, valid}, 32'd1);

    // Exhaustive sweep against hand-written truth tables.
    for (int i = 0; i < 16; i++) begin
      drive(i[3:0]);
      exp_q.push_back({y_tbl[i], eq_tbl[i], lt_tbl[i]});
      after_edge();
      got = exp_q.pop_front();
      check($sformatf("sweep_%0d", i), {29'd0, y, eq, lt}, {29'd0, got});
    end

    // Latency: a mid-cycle change shows only after the next edge.
    drive(4'b0000);
    after_edge();
    check("lat_before", {31'd0, y}, 32'd0);
    #2 {a, b, c, d} = 4'b1000;
    #1 check("lat_midcycle", {31'd0, y}, 32'd0);
    after_edge();
    check("lat_after", {31'd0, y}, 32'd1);
    // Glitches between edges are invisible.
    #2 {a, b, c, d} = 4'b0001;
    #1 {a, b, c, d} = 4'b1000;
    after_edge();
    check("glitch_hold", {29'd0, y, eq, lt}, 32'b100);

    // Reset mid-operation with Y high.
    drive(4'b1100);
    after_edge();
    check("mid_pre", {31'd0, y}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    after_edge();
    check("mid_rst_flags", {29'd0, y, eq, lt}, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    after_edge();
    check("mid_release", {28'd0, y, eq, lt, valid}, 32'b1001);

`ifdef SYSTEMX_TOGGLE_CNT_EN
    // Alternate gt/lt every cycle so Y toggles each edge; must saturate.
    for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 4'b0100 : 4'b0001);
    after_edge();
    check("tog_saturate", {24'd0, toggles}, 32'd255);
    @(negedge clk);
    rst = 1'b1;
    after_edge();
    check("tog_reset", {24'd0, toggles}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (3) after_edge();
    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
